text_console_writer: RTL

Producer side of the character-grid write interface: accepts a stream of ASCII bytes from the messenger/keyboard path and drives the `ascii_code` / `input_x` / `input_y` triple consumed by the VGA character display. It owns the text cursor and interprets control characters: newline, backspace and optional clear-screen. The display commits a cell write on any cycle-to-cycle change of that triple, so this block guarantees one distinct, stable triple per intended write.

---
 rtl/text_console_pkg.sv | 28 ++
 rtl/text_cursor_next.sv | 62 ++++++
 rtl/text_console_writer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/text_console_pkg.sv
// text_console_pkg
//   Shared constants and types for the text console writer.
//   - ASCII control/printable constants used to decode the input stream
//   - Default grid size (40x30 cells of 16x16 px on a 640x480 screen)
//   - FSM state type and the cursor-update operation type
//   Build option: TEXT_CLEAR_EN adds the CLEAR state for the clear-screen sweep.
package text_console_pkg;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  localparam int DEFAULT_COLS = 40;
  localparam int DEFAULT_ROWS = 30;

`ifdef TEXT_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_CLEAR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD} state_t;
`endif

  typedef enum logic [1:0] {OP_ADVANCE, OP_NEWLINE, OP_BACKSPACE} cursor_op_t;

endpackage

// File: rtl/text_cursor_next.sv
// text_cursor_next
//   Combinational next-cursor calculation shared by the printable, newline
//   and backspace paths. Wrapping is done with compares against COLS-1 and
//   ROWS-1 (no modulo); there is no scrolling, the last row wraps to row 0.
//   Ports:
//     x, y           : current cursor column / row
//     op             : advance, newline or backspace
//     next_x, next_y : cursor after applying op
module text_cursor_next
  import text_console_pkg::*;
#(
  parameter int COLS = DEFAULT_COLS,
  parameter int ROWS = DEFAULT_ROWS
) (
  input  logic [5:0] x,
  input  logic [5:0] y,
  input  cursor_op_t op,
  output logic [5:0] next_x,
  output logic [5:0] next_y
);

  localparam logic [5:0] X_MAX = 6'(COLS - 1);
  localparam logic [5:0] Y_MAX = 6'(ROWS - 1);

  logic [5:0] y_down;

  // Row advance with wrap from the last row back to the top.
  assign y_down = (y == Y_MAX) ? 6'd0 : y + 6'd1;

  always_comb begin
    next_x = x;
    next_y = y;
    case (op)
      OP_ADVANCE: begin
        if (x == X_MAX) begin
          next_x = 6'd0;
          next_y = y_down;
        end else begin
          next_x = x + 6'd1;
        end
      end
      OP_NEWLINE: begin
        next_x = 6'd0;
        next_y = y_down;
      end
      OP_BACKSPACE: begin
        // At the top-left corner the cursor stays put.
        if (x != 6'd0) begin
          next_x = x - 6'd1;
        end else if (y != 6'd0) begin
          next_x = X_MAX;
          next_y = y - 6'd1;
        end
      end
      default: begin
        next_x = x;
        next_y = y;
      end
    endcase
  end

endmodule

// File: rtl/text_console_writer.sv
// text_console_writer
//   Turns a byte stream into (ascii_code, out_x, out_y) cell writes for the
//   VGA character display. The display commits a write on any change of
//   that triple, so every write is held for a HOLD cycle before the next.
//   Ports:
//     FPGA_clock, iRST_n  : clock, asynchronous active-low reset
//     in_valid, in_char   : byte source (held while not accepted)
//     in_ready            : high in IDLE, byte accepted on valid && ready
//     ascii_code,out_x,out_y : registered write triple to the display
//     cursor_x, cursor_y  : current text cursor
//     busy                : high in HOLD or CLEAR
//   Build option: TEXT_CLEAR_EN makes 0x0C sweep spaces over the whole grid;
//   without it 0x0C is ignored like any unsupported byte.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int COLS = DEFAULT_COLS,
  parameter int ROWS = DEFAULT_ROWS
) (
  input  logic       FPGA_clock,
  input  logic       iRST_n,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  output logic [7:0] ascii_code,
  output logic [5:0] out_x,
  output logic [5:0] out_y,
  output logic [5:0] cursor_x,
  output logic [5:0] cursor_y,
  output logic       busy
);

`ifdef TEXT_CLEAR_EN
  localparam logic [5:0] X_MAX = 6'(COLS - 1);
  localparam logic [5:0] Y_MAX = 6'(ROWS - 1);
`endif

  state_t     state;
  cursor_op_t op;
  logic [5:0] next_x;
  logic [5:0] next_y;
  logic       is_printable;
  logic       accept;

  // Decode which cursor update the incoming byte would need.
  always_comb begin
    op = OP_ADVANCE;
    if (in_char == CH_BS) begin
      op = OP_BACKSPACE;
    end else if (in_char == CH_LF || in_char == CH_CR) begin
      op = OP_NEWLINE;
    end
  end

  assign is_printable = (in_char >= CH_PRINT_LO) && (in_char <= CH_PRINT_HI);
  assign accept       = in_valid && in_ready;

  text_cursor_next #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor_next (
    .x     (cursor_x),
    .y     (cursor_y),
    .op    (op),
    .next_x(next_x),
    .next_y(next_y)
  );

  // Control FSM. All outputs are registered; in_ready/busy are updated on
  // the same edge as the state so they always reflect the current state.
  // The CLEAR sweep reuses out_x/out_y as its position counters.
  always_ff @(posedge FPGA_clock or negedge iRST_n) begin
    if (!iRST_n) begin
      state      <= ST_IDLE;
      ascii_code <= CH_SPACE;
      out_x      <= 6'd0;
      out_y      <= 6'd0;
      cursor_x   <= 6'd0;
      cursor_y   <= 6'd0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_printable) begin
              ascii_code <= in_char;
              out_x      <= cursor_x;
              out_y      <= cursor_y;
              cursor_x   <= next_x;
              cursor_y   <= next_y;
              state      <= ST_HOLD;
              in_ready   <= 1'b0;
              busy       <= 1'b1;
            end else if (op == OP_BACKSPACE) begin
              // Erase happens at the cell the cursor moves back to.
              ascii_code <= CH_SPACE;
              out_x      <= next_x;
              out_y      <= next_y;
              cursor_x   <= next_x;
              cursor_y   <= next_y;
              state      <= ST_HOLD;
              in_ready   <= 1'b0;
              busy       <= 1'b1;
            end else if (op == OP_NEWLINE) begin
              cursor_x <= next_x;
              cursor_y <= next_y;
`ifdef TEXT_CLEAR_EN
            end else if (in_char == CH_FF) begin
              ascii_code <= CH_SPACE;
              out_x      <= 6'd0;
              out_y      <= 6'd0;
              state      <= ST_CLEAR;
              in_ready   <= 1'b0;
              busy       <= 1'b1;
`endif
            end
          end
        end
        ST_HOLD: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
`ifdef TEXT_CLEAR_EN
        ST_CLEAR: begin
          if (out_x == X_MAX && out_y == Y_MAX) begin
            cursor_x <= 6'd0;
            cursor_y <= 6'd0;
            state    <= ST_HOLD;
          end else if (out_x == X_MAX) begin
            out_x <= 6'd0;
            out_y <= out_y + 6'd1;
          end else begin
            out_x <= out_x + 6'd1;
          end
        end
`endif
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
